mul_result_stage: RTL and testbench

- Downstream consumer of the combinational 16x16 Booth multiplier top.
- Registers the 32-bit product, derives the negative and zero flags, and buffers results in a 2-entry FIFO/skid buffer.
- Presents results on a valid/ready interface to the ALU writeback path.
- Decouples the multiplier's combinational path from writeback timing and backpressure.

---
 rtl/mul_result_stage.sv | 176 +++++++++++++++++
 tb/tb_mul_result_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_stage.sv
// mul_result_stage
//   Result stage behind the combinational 16x16 Booth multiplier. Each
//   accepted product is registered together with its negative/zero flags and
//   an opaque tag in a 2-entry FIFO (skid buffer). The buffer presents the
//   oldest entry to the ALU writeback path on a valid/ready interface.
//   There is no combinational path from the in_* side to the out_* side.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. Valid never waits for ready. in_ready is a function of the
//   registered occupancy only, so it never depends on out_ready.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   upstream handshake
//   in_prod          product from the multiplier (PROD_W bits)
//   in_signed        product came from a signed multiply
//   in_tag           tag carried with the result (TAG_W bits)
//   out_valid/ready  downstream handshake
//   out_prod/neg/zero/tag  head entry payload
//   done_cnt         saturating count of output handshakes (CNT_W bits)
//   stall_cnt        saturating count of cycles with out_valid & !out_ready
//                    (present only when MUL_RESULT_STALL_CNT_EN is defined)
//
// Optional feature macro: MUL_RESULT_STALL_CNT_EN
module mul_result_stage #(
    parameter int PROD_W = 32,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_signed,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic              out_neg,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag,
`ifdef MUL_RESULT_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [CNT_W-1:0]  done_cnt
);

    // The state is the occupancy itself (0, 1 or 2 entries held).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic push;
    logic pop;
    logic wr_ptr;
    logic rd_ptr;
    logic neg_in;
    logic zero_in;

    logic [PROD_W-1:0] mem_prod [2];
    logic              mem_neg  [2];
    logic              mem_zero [2];
    logic [TAG_W-1:0]  mem_tag  [2];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Flags are frozen at push time; an unsigned product is never negative.
    assign neg_in  = in_signed & in_prod[PROD_W-1];
    assign zero_in = (in_prod == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // ---------------- storage and pointers ----------------
    // Storage is cleared on reset so the head payload reads as zero
    // immediately, not just once out_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_prod[i] <= '0;
                mem_neg[i]  <= 1'b0;
                mem_zero[i] <= 1'b0;
                mem_tag[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_prod[wr_ptr] <= in_prod;
                mem_neg[wr_ptr]  <= neg_in;
                mem_zero[wr_ptr] <= zero_in;
                mem_tag[wr_ptr]  <= in_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign out_prod = mem_prod[rd_ptr];
    assign out_neg  = mem_neg[rd_ptr];
    assign out_zero = mem_zero[rd_ptr];
    assign out_tag  = mem_tag[rd_ptr];

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (pop && (done_cnt != '1)) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

`ifdef MUL_RESULT_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed testbench for mul_result_stage: single result, flag rules,
// backpressure, streaming, asynchronous reset mid-operation and done_cnt
// saturation. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, away from the active edge.
module tb_mul_result_stage;

    localparam int PROD_W = 32;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_signed;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_prod;
    logic              out_neg;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  done_cnt;
`ifdef MUL_RESULT_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_checks;
    int n_pass;

    // Scoreboard entry: {prod, neg, zero, tag}
    logic [PROD_W+TAG_W+1:0] exp_q[$];

    mul_result_stage #(
        .PROD_W(PROD_W),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .in_signed(in_signed),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod (out_prod),
        .out_neg  (out_neg),
        .out_zero (out_zero),
        .out_tag  (out_tag),
`ifdef MUL_RESULT_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done_cnt (done_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PROD_W-1:0] p, input logic s,
                         input logic [TAG_W-1:0] t);
        in_valid  = v;
        in_prod   = p;
        in_signed = s;
        in_tag    = t;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    // Push one entry with out_ready=1, check the head, then let it pop.
    task automatic push_and_check(input string name, input logic [PROD_W-1:0] p,
                                  input logic s, input logic [TAG_W-1:0] t,
                                  input logic exp_neg, input logic exp_zero);
        out_ready = 1'b1;
        drive(1'b1, p, s, t);
        step();
        idle();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_prod"},  out_prod, p);
        check({name, "_neg"},   out_neg, exp_neg);
        check({name, "_zero"},  out_zero, exp_zero);
        check({name, "_tag"},   out_tag, t);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PROD_W-1:0] sp;
        logic              ss;
        logic              sn;
        logic              sz;
        int                ready_drops;

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();

        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_prod",  out_prod, 0);
        check("rst_out_tag",   out_tag, 0);
        check("rst_done_cnt",  done_cnt, 0);

        // Release reset between edges with a push already offered:
        // the very next edge must accept it.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFE, 1'b1, 4'd3);
        step();
        idle();
        check("single_valid", out_valid, 1);
        check("single_prod",  out_prod, 32'hFFFF_FFFE);
        check("single_neg",   out_neg, 1);
        check("single_zero",  out_zero, 0);
        check("single_tag",   out_tag, 3);
        check("single_cnt0",  done_cnt, 0);
        step();
        check("single_cnt1",  done_cnt, 1);
        check("single_empty", out_valid, 0);

        // Flag rules
        push_and_check("msb_unsigned", 32'h8000_0000, 1'b0, 4'd4, 1'b0, 1'b0);
        push_and_check("msb_signed",   32'h8000_0000, 1'b1, 4'd5, 1'b1, 1'b0);
        push_and_check("zero_signed",  32'h0000_0000, 1'b1, 4'd6, 1'b0, 1'b1);
        check("flags_done_cnt", done_cnt, 4);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0011, 1'b0, 4'd1);
        step();
        check("bp_ready_after1", in_ready, 1);
        check("bp_tag_after1",   out_tag, 1);
        drive(1'b1, 32'h0000_0022, 1'b0, 4'd2);
        step();
        check("bp_ready_full",   in_ready, 0);
        check("bp_valid_full",   out_valid, 1);
        drive(1'b1, 32'h0000_0033, 1'b0, 4'd9);   // must be ignored
        step();
        idle();
        check("bp_ready_hold",   in_ready, 0);
        check("bp_tag_hold",     out_tag, 1);
        check("bp_prod_hold",    out_prod, 32'h0000_0011);
        step();
        step();
        check("bp_tag_hold2",    out_tag, 1);
`ifdef MUL_RESULT_STALL_CNT_EN
        check("bp_stall_cnt",    stall_cnt, 4);
`endif
        out_ready = 1'b1;
        step();
        check("bp_pop1_next_tag",  out_tag, 2);
        check("bp_pop1_next_prod", out_prod, 32'h0000_0022);
        check("bp_pop1_valid",     out_valid, 1);
        step();
        check("bp_drained",      out_valid, 0);
        check("bp_done_cnt",     done_cnt, 6);

        // Streaming: one push per cycle, each head seen exactly one cycle later
        ready_drops = 0;
        out_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sp = i[0] ? (32'h8000_0000 | i) : (i * 2);
            ss = i[1];
            sn = ss & i[0];
            sz = (i == 0);
            if (!in_ready) ready_drops++;
            drive(1'b1, sp, ss, i[3:0]);
            exp_q.push_back({sp, sn, sz, i[3:0]});
            step();
            check("stream_valid", out_valid, 1);
            check("stream_head", {out_prod, out_neg, out_zero, out_tag}, exp_q.pop_front());
        end
        idle();
        if (!in_ready) ready_drops++;
        check("stream_ready_drops", ready_drops, 0);
        step();
        check("stream_drained",  out_valid, 0);
        check("stream_done_cnt", done_cnt, 106);

        // Reset mid-operation from FULL, asserted between edges
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0AAA, 1'b0, 4'd10);
        step();
        drive(1'b1, 32'h0000_0BBB, 1'b0, 4'd11);
        step();
        idle();
        check("pre_rst_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_done",  done_cnt, 0);
        check("mid_rst_prod",  out_prod, 0);
        check("mid_rst_tag",   out_tag, 0);
`ifdef MUL_RESULT_STALL_CNT_EN
        check("mid_rst_stall", stall_cnt, 0);
`endif
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_005A, 1'b0, 4'd7);
        step();
        idle();
        check("post_rst_tag",  out_tag, 7);
        check("post_rst_prod", out_prod, 32'h0000_005A);
        step();
        check("post_rst_empty", out_valid, 0);
        check("post_rst_done",  done_cnt, 1);

        // Saturation: 65533 more pops bring done_cnt to 0xFFFE
        drive(1'b1, 32'h0000_0001, 1'b0, 4'd1);
        for (int i = 0; i < 65533; i++) begin
            step();
        end
        idle();
        step();
        check("sat_fffe", done_cnt, 16'hFFFE);
        push_and_check("sat_a", 32'h0000_0002, 1'b0, 4'd2, 1'b0, 1'b0);
        check("sat_ffff", done_cnt, 16'hFFFF);
        push_and_check("sat_b", 32'h0000_0003, 1'b0, 4'd3, 1'b0, 1'b0);
        check("sat_hold", done_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
